// File: rtl/bcd_counter_scan.sv
// Multi-digit BCD up/down counter with a free-running digit scanner that
// presents one digit at a time (plus one-hot select) to a shared 7-seg decoder.

module bcd_digit_step (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);
    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= 4'd9) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = 4'd9;
                    cout = 1'b1;
                end else if (d > 4'd9) begin
                    q = 4'd9;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_counter_scan #(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic              en,
    input  logic              up,
    output logic [4*NDIG-1:0] count,
    output logic              wrap,
    output logic [3:0]        bcd_out,
    output logic [NDIG-1:0]   dig_sel,
    output logic [2:0]        dig_idx
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [NDIG-1:0][3:0] cnt_q, cnt_nxt, ld_val, ld_clamp;
    logic [NDIG:0]        carry;
    logic [PW-1:0]        presc;
    logic [2:0]           idx_nxt;

    assign ld_val   = load_val;
    assign count    = cnt_q;
    assign carry[0] = 1'b1;

    // Ripple carry/borrow chain; the last carry-out is the wrap condition.
    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        bcd_digit_step u_step (
            .d    (cnt_q[i]),
            .up   (up),
            .cin  (carry[i]),
            .q    (cnt_nxt[i]),
            .cout (carry[i+1])
        );
        assign ld_clamp[i] = (ld_val[i] > 4'd9) ? 4'd9 : ld_val[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            cnt_q <= ld_clamp;
            wrap  <= 1'b0;
        end else if (en) begin
            cnt_q <= cnt_nxt;
            wrap  <= carry[NDIG];
        end else begin
            wrap  <= 1'b0;
        end
    end

    assign idx_nxt = (dig_idx >= 3'(NDIG - 1)) ? 3'd0 : dig_idx + 3'd1;

    // Index and select advance on the same edge so they never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            dig_idx <= 3'd0;
            dig_sel <= NDIG'(1);
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc   <= '0;
            dig_idx <= idx_nxt;
            dig_sel <= NDIG'(1) << idx_nxt;
        end else begin
            presc   <= presc + PW'(1);
        end
    end

    always_comb begin
        bcd_out = 4'd0;
        for (int i = 0; i < NDIG; i++)
            if (dig_idx == 3'(i)) bcd_out = cnt_q[i];
    end
endmodule
